// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input conditioner.
package input_cond_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 4;
    localparam int GLITCH_W        = 8;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle of the conditioner's control inputs and conditioned outputs.
// The master side drives raw inputs; the slave side is the conditioner.
interface input_conditioner_if
    import input_cond_pkg::*;
#(
    parameter int CH = 8
);

    logic                   en;
    logic [CH-1:0]          ix;
    logic [CH-1:0]          clr;
    logic [CH-1:0]          z;
    logic [CH-1:0]          rise;
    logic [CH-1:0]          fall;
    logic [CH-1:0]          sticky;
    logic [GLITCH_W*CH-1:0] glitch_cnt;

    modport master (
        output en, ix, clr,
        input  z, rise, fall, sticky, glitch_cnt
    );

    modport slave (
        input  en, ix, clr,
        output z, rise, fall, sticky, glitch_cnt
    );

endinterface

// File: rtl/input_cond_ch.sv
// One conditioner channel: synchroniser, debounce counter, level,
// edge pulses, sticky rise flag and optional glitch counter.
// Optional glitch counter enabled by defining INPUT_COND_GLITCH_CNT_EN.
module input_cond_ch
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                ix,
    input  logic                clr,
    output logic                z,
    output logic                rise,
    output logic                fall,
    output logic                sticky,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int               CNT_W    = clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] s;
    logic [CNT_W-1:0]       cnt;
    logic                   sy;
    logic                   mismatch;
    logic                   accept;

    assign sy       = s[SYNC_STAGES-1];
    assign mismatch = sy ^ z;
    // The edge on which z takes the new level.
    assign accept   = en & mismatch & (cnt == CNT_LAST);

    // Synchroniser chain, free-running regardless of en.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s <= '0;
        end else begin
            s <= {s[SYNC_STAGES-2:0], ix};
        end
    end

    // Debounce: count consecutive mismatches, adopt sy after DB_CYCLES of them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            z   <= 1'b0;
        end else if (en) begin
            if (!mismatch) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                z   <= sy;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Edge pulses, registered alongside the new z.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept & sy;
            fall <= accept & ~sy;
        end
    end

    // Sticky rise flag; a set on the same edge as clr wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sticky <= 1'b0;
        end else begin
            sticky <= (accept & sy) | (sticky & ~clr);
        end
    end

`ifdef INPUT_COND_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] gcnt;
    logic                glitch_end;

    // A short mismatch run that collapses back to z is a rejected glitch.
    assign glitch_end = en & ~mismatch & (cnt != '0);

    // Saturating rejected-glitch counter, cleared by clr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gcnt <= '0;
        end else if (clr) begin
            gcnt <= '0;
        end else if (glitch_end && (gcnt != '1)) begin
            gcnt <= gcnt + 1'b1;
        end
    end

    assign glitch_cnt = gcnt;
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// N-channel input conditioner: an array of independent channels packed
// onto the conditioner interface.
// Optional per-channel glitch counters enabled by INPUT_COND_GLITCH_CNT_EN.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input_conditioner_if.slave  bus
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        input_cond_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (bus.en),
            .ix         (bus.ix[i]),
            .clr        (bus.clr[i]),
            .z          (bus.z[i]),
            .rise       (bus.rise[i]),
            .fall       (bus.fall[i]),
            .sticky     (bus.sticky[i]),
            .glitch_cnt (bus.glitch_cnt[GLITCH_W*i +: GLITCH_W])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios followed by random
// traffic, each cycle compared against a run-length reference model.
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int CH  = 8;
    localparam int SS  = SYNC_STAGES_DEF;
    localparam int DB  = DB_CYCLES_DEF;
    localparam int LAT = SS + DB - 1;
`ifdef INPUT_COND_GLITCH_CNT_EN
    localparam int GLITCH_ON = 1;
`else
    localparam int GLITCH_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    input_conditioner_if #(.CH(CH)) bus();

    input_conditioner #(
        .CH          (CH),
        .SYNC_STAGES (SS),
        .DB_CYCLES   (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: ix delayed by SS edges, then a mismatch run length.
    logic [CH-1:0] hist [SS];
    logic [CH-1:0] m_z, m_rise, m_fall, m_sticky;
    int            m_run    [CH];
    int            m_glitch [CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) hist[k] = '0;
        m_z = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
        for (int i = 0; i < CH; i++) begin
            m_run[i]    = 0;
            m_glitch[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [CH-1:0] sy;
        if (!rst) begin
            model_reset();
        end else begin
            sy = hist[SS-1];
            for (int i = 0; i < CH; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (bus.en) begin
                    if (sy[i] != m_z[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_z[i]   = sy[i];
                            m_run[i] = 0;
                            if (sy[i]) m_rise[i] = 1'b1;
                            else       m_fall[i] = 1'b1;
                        end
                    end else begin
                        if (GLITCH_ON != 0 && m_run[i] > 0 && m_glitch[i] < 255)
                            m_glitch[i]++;
                        m_run[i] = 0;
                    end
                end
                m_sticky[i] = m_rise[i] | (m_sticky[i] & ~bus.clr[i]);
                if (bus.clr[i]) m_glitch[i] = 0;
            end
            for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = bus.ix;
        end
    endtask

    function automatic logic [63:0] model_glitch();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[8*i +: 8] = 8'(m_glitch[i]);
        return v;
    endfunction

    // One clock edge: advance the model, then compare every output.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("z",          64'(bus.z),          64'(m_z));
        check("rise",       64'(bus.rise),       64'(m_rise));
        check("fall",       64'(bus.fall),       64'(m_fall));
        check("sticky",     64'(bus.sticky),     64'(m_sticky));
        check("glitch_cnt", 64'(bus.glitch_cnt), model_glitch());
    endtask

    initial begin
        logic [CH-1:0] all1;
        all1     = '1;
        bus.en   = 1'b1;
        bus.ix   = '0;
        bus.clr  = '0;
        rst      = 1'b0;
        model_reset();

        // Reset held with inputs high: everything stays cleared.
        bus.ix = '1;
        repeat (3) step();
        check("rst_z",      64'(bus.z),          64'h0);
        check("rst_sticky", 64'(bus.sticky),     64'h0);
        check("rst_glitch", 64'(bus.glitch_cnt), 64'h0);

        // Release: z follows after the full latency, one rise pulse.
        rst = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            step();
            check("rel_z",    64'(bus.z),    (k >= LAT) ? 64'(all1) : 64'h0);
            check("rel_rise", 64'(bus.rise), (k == LAT) ? 64'(all1) : 64'h0);
        end

        // Settle all channels low and clear the sticky flags.
        bus.ix = '0;
        repeat (LAT + 3) step();
        bus.clr = '1;
        step();
        bus.clr = '0;
        check("clr_sticky", 64'(bus.sticky), 64'h0);

        // Clean rising edge on channel 3.
        bus.ix[3] = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            step();
            if (k == LAT - 1) check("ch3_early_z", 64'(bus.z), 64'h00);
            if (k == LAT) begin
                check("ch3_z",      64'(bus.z),      64'h08);
                check("ch3_rise",   64'(bus.rise),   64'h08);
                check("ch3_sticky", 64'(bus.sticky), 64'h08);
            end
            if (k == LAT + 1) check("ch3_rise_end", 64'(bus.rise), 64'h00);
        end

        // Short pulse on channel 0 is rejected and counted.
        bus.ix[0] = 1'b1;
        repeat (DB - 1) step();
        bus.ix[0] = 1'b0;
        repeat (LAT + 1) step();
        check("glitch_z",   64'(bus.z),               64'h08);
        check("glitch_one", 64'(bus.glitch_cnt[7:0]), 64'(GLITCH_ON));
        for (int n = 0; n < 299; n++) begin
            bus.ix[0] = 1'b1;
            repeat (DB - 1) step();
            bus.ix[0] = 1'b0;
            repeat (SS + 1) step();
        end
        check("glitch_sat", 64'(bus.glitch_cnt[7:0]), (GLITCH_ON != 0) ? 64'd255 : 64'd0);
        check("glitch_z2",  64'(bus.z),               64'h08);

        // Sticky: set and clr on the same edge, set wins; clr alone clears.
        bus.ix[2] = 1'b1;
        repeat (LAT) step();
        bus.clr[2] = 1'b1;
        step();
        check("stk_set_wins", 64'(bus.sticky), 64'h0C);
        step();
        check("stk_cleared", 64'(bus.sticky), 64'h08);
        bus.clr = '0;

        // Enable freeze: z holds while en is low, then DB more edges.
        bus.en    = 1'b0;
        bus.ix[1] = 1'b1;
        repeat (10) step();
        check("frz_z", 64'(bus.z), 64'h0C);
        bus.en = 1'b1;
        for (int k = 1; k <= DB; k++) begin
            step();
            if (k == DB - 1) check("frz_early_z", 64'(bus.z), 64'h0C);
            if (k == DB) begin
                check("frz_z_new", 64'(bus.z),    64'h0E);
                check("frz_rise",  64'(bus.rise), 64'h02);
            end
        end

        // Reset mid-debounce on channel 5: full latency re-applies.
        bus.ix[5] = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();
        check("mid_rst_z", 64'(bus.z), 64'h00);
        rst = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            step();
            if (k == LAT - 1) check("mid_early_z", 64'(bus.z), 64'h00);
            if (k == LAT)     check("mid_z",       64'(bus.z), 64'h2E);
        end

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(5) == 0) bus.ix[i] = ~bus.ix[i];
                bus.clr[i] = ($urandom_range(15) == 0);
            end
            bus.en = ($urandom_range(9) != 0);
            rst    = ($urandom_range(199) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
